// File: rtl/acc_seq_if.sv
// ---------------------------------------------------------------------------
// acc_seq_if
//   Host-facing bundle of the accelerator sequencer: the beat-write channel,
//   the abort request and the result valid/ready channel.
//   master : host side (drives beats, abort, res_ready)
//   slave  : sequencer side (drives host_wready and the result channel)
// Signals
//   host_wvalid / host_wready / host_wdata : input beat handshake
//   host_abort                             : level abort request
//   res_valid / res_ready                  : result handshake
//   res_data / res_timeout                 : result payload and timeout flag
// ---------------------------------------------------------------------------
interface acc_seq_if #(
    parameter int WORD_W    = 32,
    parameter int OUT_WIDTH = 4
) ();
    logic                 host_wvalid;
    logic                 host_wready;
    logic [WORD_W-1:0]    host_wdata;
    logic                 host_abort;
    logic                 res_valid;
    logic                 res_ready;
    logic [OUT_WIDTH-1:0] res_data;
    logic                 res_timeout;

    modport master (
        output host_wvalid, host_wdata, host_abort, res_ready,
        input  host_wready, res_valid, res_data, res_timeout
    );

    modport slave (
        input  host_wvalid, host_wdata, host_abort, res_ready,
        output host_wready, res_valid, res_data, res_timeout
    );
endinterface

// File: rtl/acc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// acc_seq_ctrl
//   Host-side sequencer for the accelerator register bank. Collects
//   IN_WIDTH/WORD_W host beats into an input buffer, commits it, pulses
//   START, waits for acc_done (bounded by TIMEOUT), captures the output
//   register and hands the result back over a valid/ready channel. A host
//   abort or a timeout issues a STOP / STOP-clear control sequence.
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   host              : acc_seq_if.slave (beats, abort, result channel)
//   busy              : sequencer not idle
//   ctrl_wr_en        : control register write strobe
//   ctrl_start_wr     : START value for the control write
//   ctrl_stop_wr      : STOP value for the control write
//   in_data_wr_en     : input register write strobe
//   in_data_wr        : assembled input vector
//   out_data_cap_en   : output register capture strobe
//   acc_done          : accelerator result valid this cycle
//   out_data_reg      : output register contents
// ---------------------------------------------------------------------------
module acc_seq_ctrl #(
    parameter int IN_WIDTH  = 1024,
    parameter int OUT_WIDTH = 4,
    parameter int WORD_W    = 32,
    parameter int TO_W      = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    acc_seq_if.slave             host,
    output logic                 busy,
    output logic                 ctrl_wr_en,
    output logic                 ctrl_start_wr,
    output logic                 ctrl_stop_wr,
    output logic                 in_data_wr_en,
    output logic [IN_WIDTH-1:0]  in_data_wr,
    output logic                 out_data_cap_en,
    input  logic                 acc_done,
    input  logic [OUT_WIDTH-1:0] out_data_reg
);
    localparam int NBEATS = IN_WIDTH / WORD_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_START,
        S_RUN,
        S_CLEAR,
        S_RESULT,
        S_STOP,
        S_STOPCLR
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic [TO_W-1:0]   timer_reg;
    logic              timeout_reg;

    logic wready;
    logic res_valid;
    logic beat_acc;
    logic last_beat;
    logic abort_req;
    logic timeout_hit;
    logic timeout_set;

    // Abort only acts in the states that own a transaction; IDLE and the
    // STOP sequence itself ignore it so a held abort cannot loop.
    assign abort_req = host.host_abort &&
                       (state_reg inside {S_LOAD, S_COMMIT, S_START, S_RUN, S_CLEAR, S_RESULT});
    assign beat_acc    = host.host_wvalid && wready;
    assign last_beat   = (beat_cnt_reg == LAST_BEAT);
    assign timeout_hit = (TIMEOUT != 0) && (timer_reg == TO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        wready          = 1'b0;
        in_data_wr_en   = 1'b0;
        ctrl_wr_en      = 1'b0;
        ctrl_start_wr   = 1'b0;
        ctrl_stop_wr    = 1'b0;
        out_data_cap_en = 1'b0;
        res_valid       = 1'b0;
        timeout_set     = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                wready = !host.host_abort;
                // NBEATS >= 2, so the first beat can never be the last.
                if (beat_acc) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                wready = !host.host_abort;
                if (abort_req) begin
                    state_next = S_STOP;
                end else if (beat_acc && last_beat) begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                in_data_wr_en = 1'b1;
                state_next    = abort_req ? S_STOP : S_START;
            end
            S_START: begin
                ctrl_wr_en    = 1'b1;
                ctrl_start_wr = 1'b1;
                state_next    = abort_req ? S_STOP : S_RUN;
            end
            S_RUN: begin
                // Priority: abort, then done, then timeout.
                if (abort_req) begin
                    state_next = S_STOP;
                end else if (acc_done) begin
                    out_data_cap_en = 1'b1;
                    state_next      = S_CLEAR;
                end else if (timeout_hit) begin
                    timeout_set = 1'b1;
                    state_next  = S_STOP;
                end
            end
            S_CLEAR: begin
                ctrl_wr_en = 1'b1;
                state_next = abort_req ? S_STOP : S_RESULT;
            end
            S_RESULT: begin
                // A same-cycle abort wins over the handshake, so the result
                // is withdrawn rather than offered and then dropped.
                res_valid = !host.host_abort;
                if (abort_req) begin
                    state_next = S_STOP;
                end else if (host.res_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_STOP: begin
                ctrl_wr_en   = 1'b1;
                ctrl_stop_wr = 1'b1;
                state_next   = S_STOPCLR;
            end
            S_STOPCLR: begin
                ctrl_wr_en = 1'b1;
                // Only a timeout has a result to report; aborts go home quietly.
                state_next = timeout_reg ? S_RESULT : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Beat counter, RUN timer, timeout flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
            timer_reg    <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if (abort_req) begin
                beat_cnt_reg <= '0;
            end else if (beat_acc) begin
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + CNT_W'(1);
            end

            // Held at zero outside RUN, so it is zero on the first RUN cycle.
            if (state_reg == S_RUN) begin
                timer_reg <= timer_reg + TO_W'(1);
            end else begin
                timer_reg <= '0;
            end

            if (abort_req) begin
                timeout_reg <= 1'b0;
            end else if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (res_valid && host.res_ready) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input buffer: one register slot per beat position
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
        logic [WORD_W-1:0] slot_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_reg <= '0;
            end else if (beat_acc && (beat_cnt_reg == CNT_W'(gi))) begin
                slot_reg <= host.host_wdata;
            end
        end

        assign in_data_wr[gi*WORD_W +: WORD_W] = slot_reg;
    end

    // ------------------------------------------------------------------
    // Host-facing outputs
    // ------------------------------------------------------------------
    assign busy             = (state_reg != S_IDLE);
    assign host.host_wready = wready;
    assign host.res_valid   = res_valid;
    assign host.res_timeout = res_valid && timeout_reg;
    assign host.res_data    = ((state_reg == S_RESULT) && !timeout_reg) ? out_data_reg : '0;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
module tb_acc_seq_ctrl;
    localparam int IN_W   = 1024;
    localparam int OUT_W  = 4;
    localparam int WW     = 32;
    localparam int NB     = IN_W / WW;
    localparam int TO_CYC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, ctrl_wr_en, ctrl_start_wr, ctrl_stop_wr, in_data_wr_en, out_data_cap_en;
    logic [IN_W-1:0]  in_data_wr;
    logic             acc_done = 1'b0;
    logic [OUT_W-1:0] acc_out_data = '0;
    logic [OUT_W-1:0] out_reg;

    acc_seq_if #(.WORD_W(WW), .OUT_WIDTH(OUT_W)) hif ();

    acc_seq_ctrl #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .WORD_W(WW), .TO_W(16), .TIMEOUT(TO_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host            (hif),
        .busy            (busy),
        .ctrl_wr_en      (ctrl_wr_en),
        .ctrl_start_wr   (ctrl_start_wr),
        .ctrl_stop_wr    (ctrl_stop_wr),
        .in_data_wr_en   (in_data_wr_en),
        .in_data_wr      (in_data_wr),
        .out_data_cap_en (out_data_cap_en),
        .acc_done        (acc_done),
        .out_data_reg    (out_reg)
    );

    always #5 clk = ~clk;

    // Output register of the accelerator bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_reg <= '0;
        else if (out_data_cap_en) out_reg <= acc_out_data;
    end

    typedef struct packed {
        logic [3:0] data;
        logic       to;
    } exp_t;

    typedef struct packed {
        logic [31:0] seed;
        logic [7:0]  done_cyc;     // RUN cycle (1-based) of acc_done; 0 = never
        logic [3:0]  acc_val;
        logic [3:0]  ready_delay;  // cycles res_ready stays low
        logic [3:0]  exp_data;
        logic        exp_to;
    } txn_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rv_cycles = 0;
    txn_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample point of the current cycle; also runs the result scoreboard.
    task automatic settle();
        exp_t e;
        #1;
        chk("strobe_onehot", 64'(($countones({in_data_wr_en, ctrl_wr_en, out_data_cap_en}) <= 1)), 64'd1);
        if (hif.res_valid) rv_cycles++;
        if (hif.res_valid && hif.res_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got data 0x%0h, expected no result", hif.res_data);
            end else begin
                e = sb_q.pop_front();
                chk("sb_res_data", 64'(hif.res_data), 64'(e.data));
                chk("sb_res_timeout", 64'(hif.res_timeout), 64'(e.to));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_start(input logic [31:0] seed);
        logic [IN_W-1:0] exp_vec;
        for (int k = 0; k < NB; k++) exp_vec[k*WW +: WW] = seed + 32'(k);
        for (int k = 0; k < NB; k++) begin
            hif.host_wvalid = 1'b1;
            hif.host_wdata  = seed + 32'(k);
            settle();
            if (k == 0) chk("wready_first", 64'(hif.host_wready), 64'd1);
            chk("commit_early", 64'(in_data_wr_en), 64'd0);
            advance();
        end
        hif.host_wvalid = 1'b0;
        hif.host_wdata  = '0;
        // COMMIT: one cycle after the last beat
        settle();
        chk("commit_en", 64'(in_data_wr_en), 64'd1);
        chk("commit_ctrl", 64'(ctrl_wr_en), 64'd0);
        chk("commit_wready", 64'(hif.host_wready), 64'd0);
        chk("in_low", 64'(in_data_wr[31:0]), 64'(seed));
        chk("in_high", 64'(in_data_wr[IN_W-1 -: WW]), 64'(seed + 32'(NB-1)));
        chk("in_full", 64'(in_data_wr == exp_vec), 64'd1);
        advance();
        // START pulse
        settle();
        chk("start_ctrl", 64'(ctrl_wr_en), 64'd1);
        chk("start_wr", 64'(ctrl_start_wr), 64'd1);
        chk("start_stopwr", 64'(ctrl_stop_wr), 64'd0);
        chk("start_inen", 64'(in_data_wr_en), 64'd0);
        chk("start_wready", 64'(hif.host_wready), 64'd0);
        advance();
    endtask

    task automatic stop_seq();
        settle();
        chk("stop_ctrl", 64'(ctrl_wr_en), 64'd1);
        chk("stop_wr", 64'(ctrl_stop_wr), 64'd1);
        chk("stop_startwr", 64'(ctrl_start_wr), 64'd0);
        chk("stop_rv", 64'(hif.res_valid), 64'd0);
        advance();
        settle();
        chk("stopclr_ctrl", 64'(ctrl_wr_en), 64'd1);
        chk("stopclr_stopwr", 64'(ctrl_stop_wr), 64'd0);
        chk("stopclr_startwr", 64'(ctrl_start_wr), 64'd0);
        advance();
    endtask

    task automatic run_txn(input txn_t t, input int idx);
        bit done = 0;
        sb_q.push_back('{data: t.exp_data, to: t.exp_to});
        load_and_start(t.seed);
        for (int c = 1; c <= TO_CYC; c++) begin
            acc_done     = (c == int'(t.done_cyc));
            acc_out_data = t.acc_val;
            settle();
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_wready", 64'(hif.host_wready), 64'd0);
            if (c == int'(t.done_cyc)) begin
                chk("run_cap", 64'(out_data_cap_en), 64'd1);
                done = 1;
            end else begin
                chk("run_nocap", 64'(out_data_cap_en), 64'd0);
                chk("run_noctrl", 64'(ctrl_wr_en), 64'd0);
            end
            advance();
            if (done) break;
        end
        acc_done = 1'b0;
        if (done) begin
            settle();
            chk("clear_ctrl", 64'(ctrl_wr_en), 64'd1);
            chk("clear_start", 64'(ctrl_start_wr), 64'd0);
            chk("clear_stop", 64'(ctrl_stop_wr), 64'd0);
            chk("clear_rv", 64'(hif.res_valid), 64'd0);
            advance();
        end else begin
            stop_seq();
        end
        for (int i = 0; i <= int'(t.ready_delay); i++) begin
            hif.res_ready = (i == int'(t.ready_delay));
            settle();
            chk("result_valid", 64'(hif.res_valid), 64'd1);
            chk("result_data", 64'(hif.res_data), 64'(t.exp_data));
            chk("result_to", 64'(hif.res_timeout), 64'(t.exp_to));
            chk("result_wready", 64'(hif.host_wready), 64'd0);
            advance();
        end
        hif.res_ready = 1'b0;
        settle();
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_wready", 64'(hif.host_wready), 64'd1);
        advance();
        $display("txn %0d: seed=0x%0h done_cyc=%0d data=0x%0h timeout=%0d", idx, t.seed, t.done_cyc,
                 t.exp_data, t.exp_to);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        //          seed          done  val   dly   exp   to
        tbl[0] = '{32'h0000_0000, 8'd5, 4'hA, 4'd3, 4'hA, 1'b0};
        tbl[1] = '{32'h0000_1000, 8'd1, 4'h3, 4'd0, 4'h3, 1'b0};
        tbl[2] = '{32'h0000_ABC0, 8'd8, 4'hF, 4'd1, 4'hF, 1'b0};  // done on the timeout cycle
        tbl[3] = '{32'h0000_0055, 8'd0, 4'h0, 4'd2, 4'h0, 1'b1};  // timeout
        tbl[4] = '{32'hDEAD_0000, 8'd2, 4'h0, 4'd0, 4'h0, 1'b0};
        tbl[5] = '{32'h1234_5600, 8'd7, 4'h6, 4'd1, 4'h6, 1'b0};

        hif.host_wvalid = 1'b0;
        hif.host_wdata  = '0;
        hif.host_abort  = 1'b0;
        hif.res_ready   = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        settle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wready", 64'(hif.host_wready), 64'd1);
        chk("rst_ctrl", 64'(ctrl_wr_en), 64'd0);
        chk("rst_inen", 64'(in_data_wr_en), 64'd0);
        chk("rst_cap", 64'(out_data_cap_en), 64'd0);
        chk("rst_rv", 64'(hif.res_valid), 64'd0);
        chk("rst_in", 64'(in_data_wr[63:0]), 64'd0);
        advance();
        rst_n = 1'b1;
        advance();

        for (int i = 0; i < 6; i++) run_txn(tbl[i], i);

        // Reset held for 2 cycles in the middle of RUN
        load_and_start(32'h0000_2000);
        for (int c = 0; c < 2; c++) begin settle(); advance(); end
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("midrst_busy", 64'(busy), 64'd0);
            chk("midrst_wready", 64'(hif.host_wready), 64'd1);
            chk("midrst_strobes", 64'({ctrl_wr_en, ctrl_start_wr, ctrl_stop_wr, in_data_wr_en, out_data_cap_en}), 64'd0);
            advance();
        end
        rst_n = 1'b1;
        run_txn(tbl[1], 10);

        // Abort ignored in IDLE
        hif.host_abort  = 1'b1;
        hif.host_wvalid = 1'b1;
        settle();
        chk("idle_abort_wready", 64'(hif.host_wready), 64'd0);
        advance();
        settle();
        chk("idle_abort_busy", 64'(busy), 64'd0);
        chk("idle_abort_ctrl", 64'(ctrl_wr_en), 64'd0);
        advance();
        hif.host_abort  = 1'b0;
        hif.host_wvalid = 1'b0;

        // Abort together with beat 10
        rv0 = rv_cycles;
        for (int k = 0; k < 10; k++) begin
            hif.host_wvalid = 1'b1;
            hif.host_wdata  = 32'h0F00 + 32'(k);
            settle();
            advance();
        end
        hif.host_wdata = 32'h0F0A;
        hif.host_abort = 1'b1;
        settle();
        chk("abort_beat_wready", 64'(hif.host_wready), 64'd0);
        advance();
        hif.host_abort  = 1'b0;
        hif.host_wvalid = 1'b0;
        stop_seq();
        settle();
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_no_result", 64'(rv_cycles - rv0), 64'd0);
        advance();
        run_txn(tbl[2], 11);

        // acc_done and abort in the same RUN cycle
        rv0 = rv_cycles;
        load_and_start(32'h0000_3000);
        for (int c = 0; c < 2; c++) begin settle(); advance(); end
        acc_done        = 1'b1;
        acc_out_data    = 4'h9;
        hif.host_abort  = 1'b1;
        settle();
        chk("abort_done_cap", 64'(out_data_cap_en), 64'd0);
        advance();
        acc_done       = 1'b0;
        hif.host_abort = 1'b0;
        stop_seq();
        settle();
        chk("abort_done_idle", 64'(busy), 64'd0);
        chk("abort_done_no_result", 64'(rv_cycles - rv0), 64'd0);
        chk("abort_done_outreg", 64'(out_reg), 64'hF);
        advance();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
